// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial multi-operand modular adder controller. It accepts up to four
//   WIDTH-bit operands and adds them one pass at a time through a single
//   shared 1-bit full adder. The full adder is two half adders plus an OR.
//   The result is returned mod 2^WIDTH over a valid/ready handshake.
//
//   Handshake: the input transfer happens on a rising edge where
//   in_valid && in_ready. The output transfer happens on a rising edge where
//   out_valid && out_ready. Once out_valid is raised, sum, ovf_cnt and
//   out_valid hold until that transfer.
//
//   Optional feature macro: SERIAL_ADD_OVF_EN
//     defined   - ovf_cnt counts the passes whose discarded carry-out was 1
//     undefined - ovf_cnt is tied to 3'd0 and no counter is built
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand set presented
//   in_ready  controller idle and able to accept (IDLE only)
//   ops       operand k at ops[k*WIDTH +: WIDTH], k = 0..3
//   op_en     operand k participates when op_en[k] = 1
//   out_valid sum available (DONE)
//   out_ready consumer takes the sum
//   sum       accumulator, sum mod 2^WIDTH
//   busy      high in any state other than IDLE
//   ovf_cnt   number of discarded carry-outs for the current result
module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*WIDTH-1:0] ops,
    input  logic [3:0]         op_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               busy,
    output logic [2:0]         ovf_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SEL, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_r [4];
    logic [3:0]       en_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opsr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic [2:0]       p;          // next operand index to consider, 1..4

    // Shared 1-bit full adder built from two half adders.
    logic ha1_s, ha1_c, ha2_s, ha2_c, c_next;
    assign ha1_s  = acc[0] ^ opsr[0];
    assign ha1_c  = acc[0] & opsr[0];
    assign ha2_s  = ha1_s ^ carry;
    assign ha2_c  = ha1_s & carry;
    assign c_next = ha1_c | ha2_c;

    logic last_bit;
    assign last_bit = (state == ADD) && (bit_cnt == LAST_BIT);

    // Lowest enabled operand with index >= p. The loop runs downward so
    // that the lowest match is the one left in sel_idx.
    logic       sel_found;
    logic [1:0] sel_idx;
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (en_r[k] && (3'(k) >= p)) begin
                sel_found = 1'b1;
                sel_idx   = 2'(k);
            end
        end
    end

    // in_ready is forced low while reset is held, even though the state
    // register already reads IDLE during reset.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            for (int k = 0; k < 4; k++) op_r[k] <= '0;
            en_r    <= '0;
            acc     <= '0;
            opsr    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            p       <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 4; k++) op_r[k] <= ops[k*WIDTH +: WIDTH];
                        en_r  <= op_en;
                        acc   <= op_en[0] ? ops[WIDTH-1:0] : '0;
                        p     <= 3'd1;
                        state <= SEL;
                    end
                end
                SEL: begin
                    if (sel_found) begin
                        opsr    <= op_r[sel_idx];
                        carry   <= 1'b0;
                        bit_cnt <= '0;
                        p       <= {1'b0, sel_idx} + 3'd1;
                        state   <= ADD;
                    end else begin
                        state <= DONE;
                    end
                end
                ADD: begin
                    // After WIDTH rotations the accumulator is back in place.
                    acc     <= {ha2_s, acc[WIDTH-1:1]};
                    opsr    <= {1'b0, opsr[WIDTH-1:1]};
                    carry   <= c_next;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) state <= SEL;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic [2:0] ovf_r;
    // The final carry of each pass is dropped from the sum but counted here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 3'd0;
        end else if (state == IDLE && in_valid) begin
            ovf_r <= 3'd0;
        end else if (last_bit && c_next) begin
            ovf_r <= ovf_r + 3'd1;
        end
    end
    assign ovf_cnt = ovf_r;
`else
    assign ovf_cnt = 3'd0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed self-checking bench for serial_add_ctrl (WIDTH = 32).
//   It covers reset values, several operand patterns with hand-computed sums,
//   latency, DONE backpressure, mid-operation reset and back-to-back sets.
module tb_serial_add_ctrl;

    localparam int WIDTH = 32;
`ifdef SERIAL_ADD_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] ops;
    logic [3:0]         op_en;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   sum;
    logic               busy;
    logic [2:0]         ovf_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ops       (ops),
        .op_en     (op_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy),
        .ovf_cnt   (ovf_cnt)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [2:0] exp_ovf(input int n);
        return OVF_ON ? 3'(n) : 3'd0;
    endfunction

    // Drives one operand set from #1 after an edge, waits for the result,
    // optionally holds backpressure for 'hold' cycles, then completes the
    // output handshake. On return the time is #1 after the edge where the
    // controller came back to IDLE, so a following call issues back-to-back.
    task automatic run_set(input string name,
                           input logic [31:0] o0, input logic [31:0] o1,
                           input logic [31:0] o2, input logic [31:0] o3,
                           input logic [3:0] en, input logic [31:0] exp_sum,
                           input int exp_lat, input logic [2:0] exp_ov,
                           input int hold);
        int wt;
        int lat;
        logic got;
        ops      = {o3, o2, o1, o0};
        op_en    = en;
        in_valid = 1'b1;
        wt = 0;
        while (!in_ready && wt < 50) begin
            @(posedge clk); #1; wt++;
        end
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        // Inputs after the accept edge must be ignored.
        in_valid = 1'b0;
        ops      = {$urandom, $urandom, $urandom, $urandom};
        op_en    = 4'($urandom_range(0, 15));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 300) begin
            @(posedge clk); #1; lat++;
            got = out_valid;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_sum"}, sum, exp_sum);
        check({name, "_ovf"}, 32'(ovf_cnt), 32'(exp_ov));
        check({name, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            ops      = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check({name, "_hold_sum"}, sum, exp_sum);
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_ovf"}, 32'(ovf_cnt), 32'(exp_ov));
            check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ops       = '0;
        op_en     = 4'b0000;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_ovf", 32'(ovf_cnt), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Directed vectors, issued back-to-back.
        run_set("all4", 32'd1, 32'd2, 32'd3, 32'd4, 4'b1111, 32'h0000000A, 100, exp_ovf(0), 0);
        run_set("wrap", 32'hFFFFFFFF, 32'h00000001, 32'h12345678, 32'h9ABCDEF0, 4'b0011,
                32'h00000000, 34, exp_ovf(1), 0);
        run_set("md5", 32'h67452301, 32'hD76AA478, 32'h0, 32'h0, 4'b0011,
                32'h3EAFC779, 34, exp_ovf(1), 10);
        run_set("only3", 32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF, 4'b1000,
                32'hDEADBEEF, 34, exp_ovf(0), 0);
        run_set("none", 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 4'b0000,
                32'h00000000, 1, exp_ovf(0), 0);
        run_set("ovf3", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111,
                32'hFFFFFFFC, 100, exp_ovf(3), 0);
        run_set("skip1", 32'h00000010, 32'h55555555, 32'h00000020, 32'h77777777, 4'b0101,
                32'h00000030, 34, exp_ovf(0), 0);

        // Reset during ADD cycle 20 of the first pass.
        ops      = {32'd0, 32'd0, 32'd9, 32'd7};
        op_en    = 4'b0011;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", sum, 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        check("abort_ovf", 32'(ovf_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_ready", 32'(in_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        run_set("after_rst", 32'd5, 32'd6, 32'd0, 32'd0, 4'b0011, 32'd11, 34, exp_ovf(0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial multi-operand modular adder controller for the MD5 round datapath. It accepts up to four WIDTH-bit operands (e.g. A + F + K[i] + M[g]) and sequences a single 1-bit full adder, built from two half adders plus an OR, one bit per cycle. It returns the sum mod 2^WIDTH over a valid/ready handshake. It trades latency for area so that one shared 1-bit adder replaces a tree of WIDTH-bit adders in the round logic.

## Interface
- WIDTH, 32, operand and sum width in bits (≥2)
- clk  in  1  rising-edge clock, single domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set presented
- in_ready  out  1  controller idle, can accept
- ops  in  4*WIDTH  operand k at ops[k*WIDTH +: WIDTH], k=0..3
- op_en  in  4  operand k participates when op_en[k]=1
- out_valid  out  1  sum available
- out_ready  in  1  consumer takes sum
- sum  out  WIDTH  result mod 2^WIDTH
- busy  out  1  high in any state other than IDLE
- ovf_cnt  out  3  count of discarded carry-outs for the current result (see Configuration)

## Operation
- States are IDLE, SEL, ADD and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture ops and op_en.
  - Load the accumulator with op0 if op_en[0], otherwise 0.
  - Clear ovf_cnt and the pass index p to 1. Go to SEL.
- SEL (1 cycle):
  - If some k≥p has op_en[k]=1, take the lowest such k.
  - Load the operand shift register with op k, clear the carry register, clear the bit counter, set p=k+1, and go to ADD.
  - Otherwise go to DONE.
- ADD (exactly WIDTH cycles):
  - Each cycle: a = acc[0], b = opsr[0], ha1 = a^b / a&b, ha2 = ha1.s^c / ha1.s&c, c_next = ha1.co|ha2.co.
  - acc <= {ha2.s, acc[WIDTH-1:1]} (rotate right). opsr shifts right.
  - On the cycle with bit counter = WIDTH-1, the final c_next is discarded (mod 2^WIDTH), ovf_cnt increments if that carry is 1, and the state goes to SEL.
- DONE:
  - out_valid=1, sum=acc.
  - On out_ready, go to IDLE.
- Disabled operands contribute no cycles.
- op_en=0000 yields sum 0.

## Timing
- With k = popcount(op_en[3:1]), out_valid rises k*(WIDTH+1)+1 cycles after the accept edge.
  - WIDTH=32, all enabled: 100 cycles.
  - k=0: 1 cycle.
- in_ready is asserted only in IDLE.
  - in_valid is ignored in every other state.
  - There is no same-cycle accept in the handshake cycle: after out_valid&out_ready, in_ready is 1 on the next cycle.
- In DONE, sum, ovf_cnt and out_valid stay stable until out_ready. out_ready outside DONE has no effect.
- ops and op_en are sampled only at the accept edge; later changes are ignored.
- Reset values are in_ready=0 while rst_n=0, then 1 in IDLE; out_valid=0; busy=0; sum=0; ovf_cnt=0. Internal registers reset to 0.
- Reset asserted mid-operation aborts immediately (asynchronously):
  - No out_valid is produced for the aborted set.
  - The first cycle after release is IDLE with in_ready=1.
- sum is the accumulator value; it is meaningful only while out_valid=1.

## Configuration
- SERIAL_ADD_OVF_EN
  - Defined: ovf_cnt counts the ADD passes whose final carry was 1 (0..3), cleared on accept and held through DONE.
  - Undefined: the counter logic is not built and ovf_cnt is tied to 3'd0.
  - Either way, sum and timing are identical.

## Test plan
- op_en=1111, ops=1,2,3,4 → sum=0x0000000A, out_valid 100 cycles after accept, ovf_cnt=0.
- op_en=0011, op0=0xFFFFFFFF, op1=0x00000001 → sum=0x00000000 after 34 cycles; ovf_cnt=1 with SERIAL_ADD_OVF_EN, 0 without.
- op_en=0011, op0=0x67452301, op1=0xD76AA478 → sum=0x3EAFC779, ovf_cnt=1. Also op_en=1000, op3=0xDEADBEEF → sum=0xDEADBEEF after 34 cycles; op_en=0000 → sum=0 after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and ops → sum, out_valid and ovf_cnt unchanged, in_ready=0. Release → IDLE next cycle.
- Reset mid-ADD (cycle 20 of the first pass) → outputs 0 immediately, no out_valid. After release, ops 5,6 with op_en=0011 → sum=11 after 34 cycles.
- Back-to-back: issue a second set on the first cycle in_ready returns → correct second sum with latency unchanged.
